spike_isi_encoder: RTL and testbench
====================================

SPIKE_ISI_ENCODER -- requirements
Module: spike_isi_encoder

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, the number of ISI FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter WIN_LOG2, default 8, giving a rate window of 2^WIN_LOG2 cycles.
REQ-003 Port clk  in  1  clock; all state updates on its rising edge.
REQ-004 Port rst  in  1  reset; asynchronous, active-high.
REQ-005 Port spike_in  in  1  spike pulse from the upstream QIF neuron; registered, may stay high for several cycles.
REQ-006 Port clr_ovf  in  1  synchronous clear of the overflow flag.
REQ-007 Port isi_ready  in  1  downstream ready.
REQ-008 Port isi_valid  out  1  FIFO head holds a valid ISI.
REQ-009 Port isi_data  out  8  unsigned ISI at the FIFO head, in clock cycles.
REQ-010 Port overflow  out  1  sticky flag: an ISI was dropped.
REQ-011 Port rate  out  8  unsigned spike count of the last completed window.

Function
REQ-012 A spike event SHALL be a rising edge: spike_in=1 in the current cycle and 0 in the previous cycle (previous-value register resets to 0).
REQ-013 The FSM SHALL have two states: IDLE (no spike since reset) and ARMED.
REQ-014 IDLE: first spike event -> ARMED; interval counter loads 1; nothing is pushed.
REQ-015 ARMED: each spike event SHALL push the current counter value and reload the counter to 1.
REQ-016 In ARMED with no event the counter SHALL increment, saturating at 255.
REQ-017 ISI value: events at cycles t0 and t1 SHALL push min(t1-t0, 255), e.g. events 3 cycles apart push 3.
REQ-018 The FIFO SHALL be first-word-fall-through: isi_valid = not empty and isi_data = head, both driven from registers.
REQ-019 A pop SHALL occur when isi_valid and isi_ready are both 1; isi_data SHALL be held while isi_valid=1 and isi_ready=0.
REQ-020 A push into an empty FIFO SHALL produce isi_valid=1 in the cycle after the event (latency 1).
REQ-021 Push while full with no pop: the new ISI SHALL be dropped and overflow set to 1; FIFO contents SHALL be unchanged.
REQ-022 Push and pop in the same cycle while full SHALL both take effect; nothing is dropped.
REQ-023 Push and pop in the same cycle while non-full SHALL leave the occupancy unchanged.
REQ-024 clr_ovf=1 SHALL clear overflow, except in a cycle that also drops an ISI, where overflow SHALL be 1 (set wins).
REQ-025 A free-running window counter of WIN_LOG2 bits SHALL wrap every 2^WIN_LOG2 cycles.
REQ-026 Window spike counter: +1 per spike event (in IDLE or ARMED), saturating at 255.
REQ-027 On the last window cycle (counter all ones), rate SHALL load the window count including any event in that cycle, and the count SHALL restart at 0.
REQ-028 rate SHALL change only on window boundaries.

Reset
REQ-029 While rst=1: state=IDLE, interval counter=0, FIFO empty, isi_valid=0, isi_data=0, overflow=0, rate=0, window counters=0, previous spike_in=0.
REQ-030 Reset asserted mid-operation SHALL discard all FIFO contents and any partial interval or window count.
REQ-031 After reset release, the first spike event SHALL be treated as in IDLE (no push).

Structure
REQ-032 A shared package SHALL hold ISI_W=8, RATE_W=8, ISI_MAX=255 and the FSM state enum {IDLE, ARMED}.
REQ-033 The FIFO SHALL be a sub-module isi_fifo (parameters width and depth; ports push, pop, din, dout, empty, full); edge detect, FSM, interval counter and rate logic SHALL stay in the top level.

Verification
REQ-034 Reset, then events at cycles 10, 13 and 20 with isi_ready=1 -> exactly two pushes, isi_data 3 then 7; isi_valid=1 in the cycle after each of cycles 13 and 20.
REQ-035 Events 300 cycles apart -> isi_data=255 (saturated).
REQ-036 isi_ready=0, 6 events 5 cycles apart -> 5 ISIs, 4 stored (all 5), last dropped, overflow=1; then clr_ovf=1 for one cycle -> overflow=0; then drain -> four 5s.
REQ-037 FIFO full, push and pop in the same cycle -> overflow stays 0 and occupancy stays 4.
REQ-038 WIN_LOG2=8, spike_in toggling every 2 cycles (64 events per window) -> rate=64 after the first window boundary; spike_in held high for a whole window -> rate=0 at the next boundary.
REQ-039 rst asserted with 2 entries queued -> isi_valid=0 immediately; after release, the next event pushes nothing.

Source files
------------

// File: rtl/spike_isi_encoder_pkg.sv
// Shared widths, limits and FSM encoding for the spike ISI encoder.
//   ISI_W   : width of one inter-spike interval sample
//   RATE_W  : width of the windowed spike-rate count
//   ISI_MAX : saturation value of the interval counter
//   state_e : IDLE (no spike seen since reset) / ARMED (interval running)
package spike_isi_encoder_pkg;

    localparam int unsigned ISI_W   = 8;
    localparam int unsigned RATE_W  = 8;
    localparam int unsigned ISI_MAX = 255;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

endpackage

// File: rtl/isi_fifo.sv
// First-word-fall-through FIFO for ISI samples.
//   clk, rst : clock, asynchronous active-high reset
//   push/din : write request and data; refused while full unless a pop
//              happens in the same cycle
//   pop      : read request; ignored while empty
//   dout     : head entry (valid while empty=0)
//   empty    : registered, FIFO holds no entries
//   full     : registered, FIFO holds DEPTH entries
module isi_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             empty_q;
    logic             full_q;
    logic             pop_ok;
    logic             push_ok;

    // A pop in the same cycle frees a slot, so a full FIFO may still accept.
    assign pop_ok  = pop && !empty_q;
    assign push_ok = push && (!full_q || pop_ok);

    always_comb begin
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointers, occupancy and flags; DEPTH is a power of two so pointers wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/spike_isi_encoder.sv
// Converts a spike pulse train into inter-spike intervals (ISIs, in clock
// cycles) queued in a FWFT FIFO, plus a windowed spike-rate count.
//   clk, rst  : clock, asynchronous active-high reset
//   spike_in  : spike level from the neuron; a rising edge is one event
//   clr_ovf   : synchronous clear of the sticky overflow flag
//   isi_ready : downstream ready; pop on isi_valid && isi_ready
//   isi_valid : FIFO head holds an ISI
//   isi_data  : ISI at FIFO head, saturating at ISI_MAX
//   overflow  : sticky, an ISI was dropped because the FIFO was full
//   rate      : spike events counted over the last completed window
module spike_isi_encoder
    import spike_isi_encoder_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIN_LOG2   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spike_in,
    input  logic              clr_ovf,
    input  logic              isi_ready,
    output logic              isi_valid,
    output logic [ISI_W-1:0]  isi_data,
    output logic              overflow,
    output logic [RATE_W-1:0] rate
);

    state_e              state_q;
    state_e              state_d;
    logic                spike_prev_q;
    logic                spike_evt_c;
    logic [ISI_W-1:0]    cnt_q;
    logic [ISI_W-1:0]    cnt_d;
    logic                push_c;
    logic                pop_c;
    logic                drop_c;
    logic                fifo_empty;
    logic                fifo_full;
    logic [WIN_LOG2-1:0] win_q;
    logic [RATE_W-1:0]   wcnt_q;
    logic [RATE_W-1:0]   wsum_c;
    logic                overflow_q;
    logic [RATE_W-1:0]   rate_q;

    // Rising-edge detect: a held-high spike counts once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) spike_prev_q <= 1'b0;
        else     spike_prev_q <= spike_in;
    end

    assign spike_evt_c = spike_in && !spike_prev_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: the first event after reset only arms the interval.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (spike_evt_c) state_d = ARMED;
            ARMED:   state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: push request and interval counter next value.
    always_comb begin
        push_c = 1'b0;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (spike_evt_c) cnt_d = ISI_W'(1);
            end
            ARMED: begin
                if (spike_evt_c) begin
                    push_c = 1'b1;
                    cnt_d  = ISI_W'(1);
                end else if (cnt_q != ISI_W'(ISI_MAX)) begin
                    cnt_d = cnt_q + ISI_W'(1);
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // Interval counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    isi_fifo #(
        .WIDTH (ISI_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .pop   (pop_c),
        .din   (cnt_q),
        .dout  (isi_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign isi_valid = !fifo_empty;
    assign pop_c     = isi_valid && isi_ready;
    assign drop_c    = push_c && fifo_full && !pop_c;

    // Sticky overflow; a drop in the same cycle overrides the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          overflow_q <= 1'b0;
        else if (drop_c)  overflow_q <= 1'b1;
        else if (clr_ovf) overflow_q <= 1'b0;
    end

    // Window count including this cycle's event, saturating.
    always_comb begin
        wsum_c = wcnt_q;
        if (spike_evt_c && (wcnt_q != {RATE_W{1'b1}})) wsum_c = wcnt_q + RATE_W'(1);
    end

    // Free-running window; rate is captured on its last cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_q  <= '0;
            wcnt_q <= '0;
            rate_q <= '0;
        end else begin
            win_q <= win_q + WIN_LOG2'(1);
            if (&win_q) begin
                rate_q <= wsum_c;
                wcnt_q <= '0;
            end else begin
                wcnt_q <= wsum_c;
            end
        end
    end

    assign overflow = overflow_q;
    assign rate     = rate_q;

endmodule

// File: tb/tb_spike_isi_encoder.sv
// Directed self-checking bench for spike_isi_encoder.
module tb_spike_isi_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       spike_in;
    logic       clr_ovf;
    logic       isi_ready;
    logic       isi_valid;
    logic [7:0] isi_data;
    logic       overflow;
    logic [7:0] rate;

    int ncmp   = 0;
    int nerr   = 0;
    int ecount = 0;
    int pops   = 0;
    int pops0  = 0;

    always #5 clk = ~clk;

    spike_isi_encoder #(
        .FIFO_DEPTH (4),
        .WIN_LOG2   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spike_in  (spike_in),
        .clr_ovf   (clr_ovf),
        .isi_ready (isi_ready),
        .isi_valid (isi_valid),
        .isi_data  (isi_data),
        .overflow  (overflow),
        .rate      (rate)
    );

    // Handshake counter used to confirm how many ISIs left the FIFO.
    always @(posedge clk) begin
        if (!rst && isi_valid && isi_ready) pops <= pops + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic edge_();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic run_to(input int t);
        while (ecount < t) edge_();
    endtask

    task automatic pulse(input int e);
        run_to(e - 1);
        spike_in = 1'b1;
        run_to(e);
        spike_in = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        spike_in  = 1'b0;
        clr_ovf   = 1'b0;
        isi_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        ecount = 0;
    endtask

    initial begin
        // Reset values
        rst       = 1'b1;
        spike_in  = 1'b0;
        clr_ovf   = 1'b0;
        isi_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(isi_valid), 0);
        chk("rst_data", 32'(isi_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_rate", 32'(rate), 0);
        rst    = 1'b0;
        ecount = 0;

        // Events at 10 (held 2 cycles), 13, 20 -> ISIs 3 and 7
        isi_ready = 1'b1;
        pops0     = pops;
        run_to(9);
        spike_in = 1'b1;
        run_to(11);
        spike_in = 1'b0;
        run_to(12);
        chk("first_evt_no_push", 32'(isi_valid), 0);
        spike_in = 1'b1;
        run_to(13);
        spike_in = 1'b0;
        chk("isi1_valid", 32'(isi_valid), 1);
        chk("isi1_data", 32'(isi_data), 3);
        run_to(14);
        chk("isi1_popped", 32'(isi_valid), 0);
        pulse(20);
        chk("isi2_valid", 32'(isi_valid), 1);
        chk("isi2_data", 32'(isi_data), 7);
        run_to(22);
        chk("two_pops", 32'(pops - pops0), 2);

        // 300 cycles apart -> saturated 255
        pulse(320);
        chk("sat_valid", 32'(isi_valid), 1);
        chk("sat_data", 32'(isi_data), 255);
        run_to(321);
        chk("sat_popped", 32'(isi_valid), 0);

        // Fill with ready low, drop the 5th ISI while clr_ovf is also high
        do_reset();
        pulse(5);
        pulse(10);
        pulse(15);
        pulse(20);
        pulse(25);
        chk("full_valid", 32'(isi_valid), 1);
        chk("full_data", 32'(isi_data), 5);
        chk("full_no_ovf", 32'(overflow), 0);
        run_to(29);
        spike_in = 1'b1;
        clr_ovf  = 1'b1;
        run_to(30);
        spike_in = 1'b0;
        clr_ovf  = 1'b0;
        chk("drop_set_wins", 32'(overflow), 1);
        chk("drop_head_held", 32'(isi_data), 5);
        clr_ovf = 1'b1;
        edge_();
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 0);
        isi_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 32'(isi_valid), 1);
            chk("drain_data", 32'(isi_data), 5);
            edge_();
        end
        chk("drain_empty", 32'(isi_valid), 0);
        isi_ready = 1'b0;

        // Full FIFO, push and pop in the same cycle
        do_reset();
        pulse(5);
        pulse(10);
        pulse(15);
        pulse(20);
        pulse(25);
        run_to(29);
        spike_in  = 1'b1;
        isi_ready = 1'b1;
        run_to(30);
        spike_in = 1'b0;
        chk("pp_no_ovf", 32'(overflow), 0);
        chk("pp_data", 32'(isi_data), 5);
        run_to(33);
        chk("pp_occ_last", 32'(isi_valid), 1);
        run_to(34);
        chk("pp_occ_empty", 32'(isi_valid), 0);
        isi_ready = 1'b0;

        // Reset with two entries queued
        do_reset();
        pulse(5);
        pulse(10);
        pulse(15);
        chk("q2_valid", 32'(isi_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(isi_valid), 0);
        chk("async_rst_data", 32'(isi_data), 0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        ecount = 0;
        pulse(3);
        chk("post_rst_no_push", 32'(isi_valid), 0);
        run_to(5);
        chk("post_rst_still_empty", 32'(isi_valid), 0);

        // Rate: toggle every 2 cycles for one window, then hold high
        do_reset();
        isi_ready = 1'b1;
        for (int e = 1; e <= 512; e++) begin
            if (e <= 256) spike_in = ((((e - 1) / 2) % 2) == 1) ? 1'b1 : 1'b0;
            else          spike_in = 1'b1;
            edge_();
            if (e == 255) chk("rate_before_boundary", 32'(rate), 0);
            if (e == 256) chk("rate_toggle", 32'(rate), 64);
            if (e == 300) chk("rate_held_mid", 32'(rate), 64);
            if (e == 511) chk("rate_held_end", 32'(rate), 64);
            if (e == 512) chk("rate_high_hold", 32'(rate), 0);
        end
        spike_in = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
